// File: rtl/sprite_coord_sched.sv
// Shares one coordinate-to-pixel converter among ball, glove1 and glove2, committing all three per frame.
// Define SPRITE_SCHED_TIMEOUT_EN to abandon a frame when conv_ack stalls for TIMEOUT cycles.
//
// state  | meaning
// IDLE   | wait for vsync falling edge
// SNAP   | capture all six game-space coordinates
// REQ    | conv_req high for object idx, wait for conv_ack
// GAP    | one idle cycle between requests
// COMMIT | publish staged pixel positions, pulse frame_done
module sprite_coord_sched #(
  parameter int TIMEOUT = 63
) (
  input  logic        vclock,
  input  logic        reset_n,
  input  logic        vsync,
  input  logic [15:0] ball_x,
  input  logic [15:0] ball_y,
  input  logic [15:0] glove1x,
  input  logic [15:0] glove1y,
  input  logic [15:0] glove2x,
  input  logic [15:0] glove2y,
  output logic        conv_req,
  output logic [15:0] conv_x,
  output logic [15:0] conv_y,
  input  logic        conv_ack,
  input  logic [10:0] conv_px,
  input  logic [9:0]  conv_py,
  output logic [10:0] ball_px,
  output logic [10:0] glove1px,
  output logic [10:0] glove2px,
  output logic [9:0]  ball_py,
  output logic [9:0]  glove1py,
  output logic [9:0]  glove2py,
  output logic        frame_done,
  output logic        busy,
  output logic        timeout_err,
  output logic        overrun
);

  typedef enum logic [2:0] {IDLE, SNAP, REQ, GAP, COMMIT} state_t;

  state_t      state, state_nx;
  logic        vsync_q;
  logic        frame_start;
  logic [1:0]  idx;
  logic [15:0] sh_x [3];
  logic [15:0] sh_y [3];
  logic [10:0] stg_px [3];
  logic [9:0]  stg_py [3];
  logic        tmo;

  assign frame_start = vsync_q & ~vsync;

  assign conv_x = (idx == 2'd1) ? sh_x[1] : (idx == 2'd2) ? sh_x[2] : sh_x[0];
  assign conv_y = (idx == 2'd1) ? sh_y[1] : (idx == 2'd2) ? sh_y[2] : sh_y[0];

`ifdef SPRITE_SCHED_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] tmr;

  // Reloaded in every non-REQ state so each REQ entry starts a full budget.
  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n)           tmr <= '0;
    else if (state != REQ)  tmr <= TW'(TIMEOUT - 1);
    else if (tmr != '0)     tmr <= tmr - 1'b1;
  end

  assign tmo = (tmr == '0);

  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n)                               timeout_err <= 1'b0;
    else if (state == REQ && !conv_ack && tmo)  timeout_err <= 1'b1;
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign tmo         = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    conv_req = 1'b0;
    case (state)
      IDLE:   if (frame_start) state_nx = SNAP;
      SNAP:   state_nx = REQ;
      REQ: begin
        conv_req = 1'b1;
        if (conv_ack)  state_nx = GAP;
        else if (tmo)  state_nx = IDLE;
      end
      GAP:    state_nx = (idx == 2'd2) ? COMMIT : REQ;
      COMMIT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      vsync_q    <= 1'b1;
      idx        <= 2'd0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      ball_px    <= '0;
      ball_py    <= '0;
      glove1px   <= '0;
      glove1py   <= '0;
      glove2px   <= '0;
      glove2py   <= '0;
      for (int i = 0; i < 3; i++) begin
        sh_x[i]   <= '0;
        sh_y[i]   <= '0;
        stg_px[i] <= '0;
        stg_py[i] <= '0;
      end
    end else begin
      state      <= state_nx;
      vsync_q    <= vsync;
      busy       <= (state_nx != IDLE);
      frame_done <= (state == COMMIT);
      if (frame_start && state != IDLE) overrun <= 1'b1;
      case (state)
        SNAP: begin
          sh_x[0] <= ball_x;
          sh_y[0] <= ball_y;
          sh_x[1] <= glove1x;
          sh_y[1] <= glove1y;
          sh_x[2] <= glove2x;
          sh_y[2] <= glove2y;
          idx     <= 2'd0;
        end
        REQ: begin
          if (conv_ack) begin
            stg_px[idx] <= conv_px;
            stg_py[idx] <= conv_py;
          end
        end
        GAP: begin
          if (idx != 2'd2) idx <= idx + 2'd1;
        end
        COMMIT: begin
          ball_px  <= stg_px[0];
          ball_py  <= stg_py[0];
          glove1px <= stg_px[1];
          glove1py <= stg_py[1];
          glove2px <= stg_px[2];
          glove2py <= stg_py[2];
        end
        default: ;
      endcase
    end
  end

endmodule
